// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and the fetch-queue entry type for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // Wide enough to hold a count of up to 4 entries.
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// Small circular fetch queue: push at tail, pop at head, flush empties it.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_data,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head_data
);

  localparam int unsigned PTR_W = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;

  fetch_entry_t     mem_q [QDEPTH];
  fetch_entry_t     mem_d [QDEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer advance with explicit wrap at QDEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: flush wins; otherwise write tail on push, advance head on pop.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[head_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC register, redirect handling and a fetch queue.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       QDEPTH   = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [WORD_W-1:0] Address,
  input  logic [WORD_W-1:0] Instruction,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] RedirectPC,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WORD_W-1:0] OutInstruction,
  output logic [WORD_W-1:0] OutPC,
  output logic [WORD_W-1:0] OutPCPlus4,
  output logic              Misaligned
);

  localparam logic [WORD_W-1:0] PC_INIT = {RESET_PC[WORD_W-1:2], 2'b00};

  logic [WORD_W-1:0] pc_q, pc_d;
  logic              misaligned_q, misaligned_d;
  logic              push, pop, out_valid;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      push_entry, head_entry;

  assign out_valid = (count != '0);

  // Fetch control: redirect overrides everything, otherwise push when room or draining.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    pop          = out_valid && OutReady;
    push         = !Redirect && ((count < CNT_W'(QDEPTH)) || pop);
    push_entry   = '{pc: pc_q, instr: Instruction};
    if (Redirect) begin
      pc_d = {RedirectPC[WORD_W-1:2], 2'b00};
      if (RedirectPC[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end
    end else if (push) begin
      pc_d = pc_q + WORD_W'(4);
    end
  end

  // PC and sticky misalignment flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q         <= PC_INIT;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk       (Clk),
    .rst_n     (Reset),
    .push      (push),
    .pop       (pop),
    .flush     (Redirect),
    .push_data (push_entry),
    .count     (count),
    .head_data (head_entry)
  );

  // Outputs read zero whenever the queue is empty, including during reset.
  assign Address        = pc_q;
  assign Misaligned     = misaligned_q;
  assign OutValid       = out_valid;
  assign OutInstruction = out_valid ? head_entry.instr : '0;
  assign OutPC          = out_valid ? head_entry.pc : '0;
  assign OutPCPlus4     = out_valid ? (head_entry.pc + WORD_W'(4)) : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit; instruction memory word i holds i*3.
module tb_instruction_fetch_unit;

  localparam int unsigned QD = 2;

  logic        Clk;
  logic        Reset;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstruction;
  logic [31:0] OutPC;
  logic [31:0] OutPCPlus4;
  logic        Misaligned;

  int total = 0;
  int bad   = 0;

  // Reference model state: expected queue contents {pc, instr}, PC, sticky flag.
  logic [63:0] sb[$];
  logic [31:0] m_pc;
  logic        m_mis;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (QD)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Address        (Address),
    .Instruction    (Instruction),
    .Redirect       (Redirect),
    .RedirectPC     (RedirectPC),
    .OutValid       (OutValid),
    .OutReady       (OutReady),
    .OutInstruction (OutInstruction),
    .OutPC          (OutPC),
    .OutPCPlus4     (OutPCPlus4),
    .Misaligned     (Misaligned)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a >> 2) * 32'd3;
  endfunction

  assign Instruction = memw(Address);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One clock cycle: drive inputs, check DUT against the model, advance the model.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
    logic        pop_m;
    logic        push_m;
    logic [63:0] e;
    Redirect   = redir;
    RedirectPC = rpc;
    OutReady   = rdy;
    #1;
    total++;
    if (Address !== m_pc) begin
      bad++;
      $display("FAIL sb_address got=%h exp=%h", Address, m_pc);
    end
    total++;
    if (OutValid !== (sb.size() != 0)) begin
      bad++;
      $display("FAIL sb_valid got=%b exp=%b", OutValid, (sb.size() != 0));
    end
    total++;
    if (Misaligned !== m_mis) begin
      bad++;
      $display("FAIL sb_misaligned got=%b exp=%b", Misaligned, m_mis);
    end
    if (sb.size() != 0) begin
      e = sb[0];
      total++;
      if ({OutPC, OutInstruction} !== e || OutPCPlus4 !== e[63:32] + 32'd4) begin
        bad++;
        $display("FAIL sb_head got pc=%h ins=%h p4=%h exp pc=%h ins=%h", OutPC, OutInstruction,
                 OutPCPlus4, e[63:32], e[31:0]);
      end
    end
    pop_m  = (sb.size() != 0) && rdy;
    push_m = !redir && ((sb.size() < QD) || pop_m);
    @(posedge Clk);
    if (pop_m) void'(sb.pop_front());
    if (redir) begin
      sb.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) m_mis = 1'b1;
    end else if (push_m) begin
      sb.push_back({m_pc, memw(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    @(negedge Clk);
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc  = 32'h0;
    m_mis = 1'b0;
  endtask

  task automatic do_reset();
    Reset    = 1'b0;
    Redirect = 1'b0;
    OutReady = 1'b0;
    @(negedge Clk);
    model_reset();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    OutReady   = 1'b0;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    total++;
    if (OutValid !== 1'b0 || Address !== 32'h0 || Misaligned !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got v=%b a=%h m=%b exp v=0 a=0 m=0", OutValid, Address, Misaligned);
    end
    total++;
    if (OutPC !== 32'h0 || OutInstruction !== 32'h0 || OutPCPlus4 !== 32'h0) begin
      bad++;
      $display("FAIL reset_out got pc=%h ins=%h p4=%h exp all 0", OutPC, OutInstruction, OutPCPlus4);
    end
    Reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'h0, 1'b1);
      total++;
      if (OutValid !== 1'b1 || OutPC !== exp_pc[k] || OutInstruction !== (exp_pc[k] >> 2) * 3) begin
        bad++;
        $display("FAIL stream_%0d got v=%b pc=%h ins=%0d exp pc=%h", k, OutValid, OutPC,
                 OutInstruction, exp_pc[k]);
      end
    end
  endtask

  task automatic test_backpressure_redirect();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'd0, 32'd4, 32'd8};
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 1'b0);
    total++;
    if (Address !== 32'd8 || OutValid !== 1'b1 || OutPC !== 32'd0) begin
      bad++;
      $display("FAIL bp_hold got a=%h v=%b pc=%h exp a=8 v=1 pc=0", Address, OutValid, OutPC);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (OutPC !== exp_pc[k]) begin
        bad++;
        $display("FAIL bp_order_%0d got=%h exp=%h", k, OutPC, exp_pc[k]);
      end
      step(1'b0, 32'h0, 1'b1);
    end
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b0);
    total++;
    if (OutValid !== 1'b0) begin
      bad++;
      $display("FAIL redir_bubble got v=%b exp=0", OutValid);
    end
    step(1'b0, 32'h0, 1'b0);
    total++;
    if (OutValid !== 1'b1 || OutPC !== 32'h40 || OutInstruction !== 32'd48) begin
      bad++;
      $display("FAIL redir_target got v=%b pc=%h ins=%0d exp v=1 pc=40 ins=48", OutValid, OutPC,
               OutInstruction);
    end
  endtask

  task automatic test_misaligned();
    step(1'b1, 32'h1E, 1'b1);
    total++;
    if (Misaligned !== 1'b1 || Address !== 32'h1C) begin
      bad++;
      $display("FAIL mis_flag got m=%b a=%h exp m=1 a=1c", Misaligned, Address);
    end
    step(1'b0, 32'h0, 1'b1);
    total++;
    if (OutPC !== 32'h1C || OutInstruction !== 32'd21) begin
      bad++;
      $display("FAIL mis_target got pc=%h ins=%0d exp pc=1c ins=21", OutPC, OutInstruction);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1);
    total++;
    if (Misaligned !== 1'b1) begin
      bad++;
      $display("FAIL mis_sticky got=%b exp=1", Misaligned);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    total++;
    if (OutPC !== 32'hFFFF_FFFC || OutPCPlus4 !== 32'h0) begin
      bad++;
      $display("FAIL wrap_first got pc=%h p4=%h exp pc=fffffffc p4=0", OutPC, OutPCPlus4);
    end
    step(1'b0, 32'h0, 1'b1);
    total++;
    if (OutPC !== 32'h0 || OutInstruction !== 32'h0) begin
      bad++;
      $display("FAIL wrap_second got pc=%h ins=%h exp 0", OutPC, OutInstruction);
    end
  endtask

  task automatic test_random();
    logic        r;
    logic [31:0] t;
    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(0, 7) == 0);
      t = $urandom & 32'h0000_03FF;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step(r, t, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    total++;
    if (OutValid !== 1'b0 || Address !== 32'h0 || Misaligned !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got v=%b a=%h m=%b exp v=0 a=0 m=0", OutValid, Address, Misaligned);
    end
    @(negedge Clk);
    model_reset();
    Reset = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    total++;
    if (OutValid !== 1'b1 || OutPC !== 32'h0 || OutInstruction !== 32'h0) begin
      bad++;
      $display("FAIL async_refetch got v=%b pc=%h exp v=1 pc=0", OutValid, OutPC);
    end
    step(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure_redirect();
    test_misaligned();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
